// File: rtl/mem_stage.sv
// mem_stage: memory-access stage of the RV32I pipeline.
// Converts byte-addressed load/store requests from EX/MEM into a word index,
// byte-lane mask and lane-replicated store data for the word-addressed
// data_mem. It also flags misaligned or illegal-width accesses, extends load
// data, and registers the result into the MEM/WB pipeline register.
//
// Ports
//   clk, rst              clock; asynchronous active-high reset
//   in_valid              EX/MEM slot holds a live instruction
//   in_load, in_store     instruction is a load / store (mutually exclusive)
//   in_funct3             RV32I width/sign code
//   in_addr               byte address from the ALU
//   in_wdata              rs2 store data
//   in_alu_result         pass-through result for non-memory instructions
//   in_rd, in_reg_write   destination register and its write enable
//   stall, flush          hold MEM/WB / kill the instruction in MEM
//   mem_store, mem_load   data_mem strobes (combinational)
//   mem_mask, mem_address, mem_wdata   data_mem byte mask, word index, data
//   mem_rdata             data_mem read data (combinational, same cycle)
//   wb_valid, wb_rd, wb_reg_write, wb_data   MEM/WB register outputs
//   wb_fault, wb_cause, wb_bad_addr          exception report
//                         (wb_cause: 0 misaligned, 1 illegal funct3)
module mem_stage #(
  parameter int unsigned MEM_WORDS = 256
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  input  logic        in_load,
  input  logic        in_store,
  input  logic [2:0]  in_funct3,
  input  logic [31:0] in_addr,
  input  logic [31:0] in_wdata,
  input  logic [31:0] in_alu_result,
  input  logic [4:0]  in_rd,
  input  logic        in_reg_write,
  input  logic        stall,
  input  logic        flush,
  output logic        mem_store,
  output logic        mem_load,
  output logic [3:0]  mem_mask,
  output logic [31:0] mem_address,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  output logic        wb_valid,
  output logic [4:0]  wb_rd,
  output logic        wb_reg_write,
  output logic [31:0] wb_data,
  output logic        wb_fault,
  output logic        wb_cause,
  output logic [31:0] wb_bad_addr
);

  localparam int unsigned IDX_W = (MEM_WORDS > 1) ? $clog2(MEM_WORDS) : 1;

  logic [1:0]  off;
  logic        illegal;
  logic        misaligned;
  logic        fault;
  logic        access;
  logic [3:0]  store_mask;
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;
  logic [31:0] ld_ext;

  logic        wb_valid_q,     wb_valid_d;
  logic [4:0]  wb_rd_q,        wb_rd_d;
  logic        wb_reg_write_q, wb_reg_write_d;
  logic [31:0] wb_data_q,      wb_data_d;
  logic        wb_fault_q,     wb_fault_d;
  logic        wb_cause_q,     wb_cause_d;
  logic [31:0] wb_bad_addr_q,  wb_bad_addr_d;

  assign off = in_addr[1:0];

  // Loads accept 0,1,2,4,5; stores accept only 0,1,2.
  always_comb begin
    illegal = 1'b0;
    if (in_load) begin
      case (in_funct3)
        3'd3, 3'd6, 3'd7: illegal = 1'b1;
        default:          illegal = 1'b0;
      endcase
    end else if (in_store) begin
      illegal = (in_funct3 >= 3'd3);
    end
  end

  always_comb begin
    misaligned = 1'b0;
    case (in_funct3)
      3'd1, 3'd5: misaligned = off[0];
      3'd2:       misaligned = (off != 2'b00);
      default:    misaligned = 1'b0;
    endcase
  end

  assign fault  = in_valid & (in_load | in_store) & (illegal | misaligned);
  // A stalled store stays off the bus until stall drops, so it commits once.
  assign access = in_valid & ~fault & ~stall & ~flush;

  assign mem_store   = access & in_store;
  assign mem_load    = access & in_load;
  assign mem_address = 32'(in_addr[IDX_W+1:2]);

  always_comb begin
    store_mask = 4'b1111;
    mem_wdata  = in_wdata;
    case (in_funct3)
      3'd0: begin
        store_mask = 4'b0001 << off;
        mem_wdata  = {4{in_wdata[7:0]}};
      end
      3'd1: begin
        store_mask = off[1] ? 4'b1100 : 4'b0011;
        mem_wdata  = {2{in_wdata[15:0]}};
      end
      default: begin
        store_mask = 4'b1111;
        mem_wdata  = in_wdata;
      end
    endcase
  end

  assign mem_mask = mem_store ? store_mask : '0;

  assign ld_byte = mem_rdata[{off, 3'b000} +: 8];
  assign ld_half = off[1] ? mem_rdata[31:16] : mem_rdata[15:0];

  always_comb begin
    case (in_funct3)
      3'd0:    ld_ext = {{24{ld_byte[7]}}, ld_byte};
      3'd4:    ld_ext = {24'h000000, ld_byte};
      3'd1:    ld_ext = {{16{ld_half[15]}}, ld_half};
      3'd5:    ld_ext = {16'h0000, ld_half};
      default: ld_ext = mem_rdata;
    endcase
  end

  always_comb begin
    wb_valid_d     = wb_valid_q;
    wb_rd_d        = wb_rd_q;
    wb_reg_write_d = wb_reg_write_q;
    wb_data_d      = wb_data_q;
    wb_fault_d     = wb_fault_q;
    wb_cause_d     = wb_cause_q;
    wb_bad_addr_d  = wb_bad_addr_q;
    if (flush) begin
      wb_valid_d     = 1'b0;
      wb_reg_write_d = 1'b0;
      wb_fault_d     = 1'b0;
    end else if (!stall) begin
      wb_valid_d     = in_valid;
      wb_rd_d        = in_rd;
      wb_reg_write_d = in_reg_write & ~fault;
      wb_data_d      = in_load ? ld_ext : in_alu_result;
      wb_fault_d     = fault;
      wb_cause_d     = illegal;
      wb_bad_addr_d  = in_addr;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wb_valid_q     <= 1'b0;
      wb_rd_q        <= '0;
      wb_reg_write_q <= 1'b0;
      wb_data_q      <= '0;
      wb_fault_q     <= 1'b0;
      wb_cause_q     <= 1'b0;
      wb_bad_addr_q  <= '0;
    end else begin
      wb_valid_q     <= wb_valid_d;
      wb_rd_q        <= wb_rd_d;
      wb_reg_write_q <= wb_reg_write_d;
      wb_data_q      <= wb_data_d;
      wb_fault_q     <= wb_fault_d;
      wb_cause_q     <= wb_cause_d;
      wb_bad_addr_q  <= wb_bad_addr_d;
    end
  end

  assign wb_valid     = wb_valid_q;
  assign wb_rd        = wb_rd_q;
  assign wb_reg_write = wb_reg_write_q;
  assign wb_data      = wb_data_q;
  assign wb_fault     = wb_fault_q;
  assign wb_cause     = wb_cause_q;
  assign wb_bad_addr  = wb_bad_addr_q;

endmodule

// File: tb/tb_mem_stage.sv
// Testbench for mem_stage: byte-level reference memory and MEM/WB model,
// scoreboard queues drained by a negedge monitor, directed scenarios plus
// randomized traffic with stalls and flushes.
module tb_mem_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, in_load, in_store;
  logic [2:0]  in_funct3;
  logic [31:0] in_addr, in_wdata, in_alu_result;
  logic [4:0]  in_rd;
  logic        in_reg_write, stall, flush;
  logic        mem_store, mem_load;
  logic [3:0]  mem_mask;
  logic [31:0] mem_address, mem_wdata, mem_rdata;
  logic        wb_valid, wb_reg_write, wb_fault, wb_cause;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data, wb_bad_addr;

  always #5 clk = ~clk;

  mem_stage #(.MEM_WORDS(256)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_load(in_load), .in_store(in_store),
    .in_funct3(in_funct3), .in_addr(in_addr), .in_wdata(in_wdata),
    .in_alu_result(in_alu_result), .in_rd(in_rd), .in_reg_write(in_reg_write),
    .stall(stall), .flush(flush),
    .mem_store(mem_store), .mem_load(mem_load), .mem_mask(mem_mask),
    .mem_address(mem_address), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_reg_write(wb_reg_write),
    .wb_data(wb_data), .wb_fault(wb_fault), .wb_cause(wb_cause),
    .wb_bad_addr(wb_bad_addr)
  );

  // data_mem stand-in driven by the DUT
  logic [31:0] dmem [256];
  assign mem_rdata = dmem[mem_address[7:0]];

  always @(posedge clk) begin : dmem_write
    logic [31:0] w;
    if (mem_store) begin
      w = dmem[mem_address[7:0]];
      for (int i = 0; i < 4; i++)
        if (mem_mask[i]) w[8*i +: 8] = mem_wdata[8*i +: 8];
      dmem[mem_address[7:0]] <= w;
    end
  end

  // Reference model: 1 KiB byte array, addressed modulo 1 KiB
  logic [7:0] ref_b [1024];

  typedef struct packed {
    logic        v, ld, st;
    logic [2:0]  f3;
    logic [31:0] addr, wdata, alu;
    logic [4:0]  rd;
    logic        rw, stall, flush;
  } req_t;

  typedef struct packed {
    logic        st, ld;
    logic [31:0] addr;
    logic [3:0]  mask;
    logic [31:0] wdata;
  } mev_t;

  typedef struct packed {
    logic [4:0]  rd;
    logic        rw;
    logic [31:0] data;
    logic        fault, cause;
    logic [31:0] bad;
  } wbe_t;

  mev_t exp_mem[$];
  wbe_t exp_wb[$];
  logic m_valid;
  wbe_t m_wb;
  int   checks = 0;
  int   errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, expv);
    end
  endtask

  function automatic logic [31:0] lanes(input logic [3:0] m);
    logic [31:0] r;
    for (int i = 0; i < 4; i++) r[8*i +: 8] = {8{m[i]}};
    return r;
  endfunction

  function automatic logic [31:0] load_value(input logic [9:0] a, input logic [2:0] f3);
    logic [7:0]  b;
    logic [15:0] h;
    b = ref_b[a];
    h = {ref_b[a + 10'd1], ref_b[a]};
    case (f3)
      3'd0:    return {{24{b[7]}}, b};
      3'd4:    return {24'h0, b};
      3'd1:    return {{16{h[15]}}, h};
      3'd5:    return {16'h0, h};
      default: return {ref_b[a + 10'd3], ref_b[a + 10'd2], ref_b[a + 10'd1], ref_b[a]};
    endcase
  endfunction

  function automatic req_t mk(input logic v, ld, st, input logic [2:0] f3,
                              input logic [31:0] addr, wdata, alu,
                              input logic [4:0] rd, input logic rw, stl, fl);
    req_t r;
    r.v = v; r.ld = ld; r.st = st; r.f3 = f3; r.addr = addr; r.wdata = wdata;
    r.alu = alu; r.rd = rd; r.rw = rw; r.stall = stl; r.flush = fl;
    return r;
  endfunction

  task automatic drive(input req_t r);
    logic [9:0]  a;
    logic [9:0]  b;
    int unsigned size;
    logic        illegal, mis, fault, access;
    logic [31:0] lv;
    logic [1:0]  lane;
    mev_t        e;
    in_valid = r.v; in_load = r.ld; in_store = r.st; in_funct3 = r.f3;
    in_addr = r.addr; in_wdata = r.wdata; in_alu_result = r.alu;
    in_rd = r.rd; in_reg_write = r.rw; stall = r.stall; flush = r.flush;

    a    = r.addr[9:0];
    size = 32'd1 << r.f3[1:0];
    if (r.ld)      illegal = (r.f3 == 3'd3) || (r.f3 == 3'd6) || (r.f3 == 3'd7);
    else if (r.st) illegal = (r.f3 >= 3'd3);
    else           illegal = 1'b0;
    mis    = (r.addr % size) != 0;
    fault  = r.v && (r.ld || r.st) && (illegal || mis);
    access = r.v && (r.ld || r.st) && !fault && !r.stall && !r.flush;
    lv     = load_value(a, r.f3);

    if (access) begin
      e.st = r.st; e.ld = r.ld; e.addr = 32'(a >> 2); e.mask = '0; e.wdata = '0;
      if (r.st) begin
        for (int unsigned i = 0; i < size; i++) begin
          b = a + 10'(i);
          lane = b[1:0];
          e.mask[lane] = 1'b1;
          e.wdata[8*lane +: 8] = r.wdata[8*i +: 8];
          ref_b[b] = r.wdata[8*i +: 8];
        end
      end
      exp_mem.push_back(e);
    end

    if (r.flush) begin
      m_valid = 1'b0;
    end else if (!r.stall) begin
      m_valid    = r.v;
      m_wb.rd    = r.rd;
      m_wb.rw    = r.rw && !fault;
      m_wb.data  = r.ld ? lv : r.alu;
      m_wb.fault = fault;
      m_wb.cause = illegal;
      m_wb.bad   = r.addr;
    end
    if (m_valid) exp_wb.push_back(m_wb);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic req_t rnd();
    req_t r;
    int unsigned k, size;
    logic [2:0] lset [5];
    lset = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5};
    r.v  = ($urandom % 8) != 0;
    k    = $urandom % 3;
    r.ld = (k == 1);
    r.st = (k == 2);
    if (($urandom % 4) != 0) r.f3 = r.ld ? lset[$urandom % 5] : lset[$urandom % 3];
    else                     r.f3 = 3'($urandom % 8);
    size   = 32'd1 << r.f3[1:0];
    r.addr = $urandom_range(0, 4095);
    if (($urandom % 2) != 0) r.addr = r.addr & ~(size - 1);
    if (($urandom % 8) == 0) r.addr = r.addr | ($urandom & 32'hFFFF_F000);
    r.wdata = $urandom;
    r.alu   = $urandom;
    r.rd    = 5'($urandom % 32);
    r.rw    = 1'($urandom % 2);
    r.stall = 1'b0;
    r.flush = 1'b0;
    return r;
  endfunction

  // Monitor: checks the memory port and pops the writeback scoreboard
  mev_t mon_e;
  wbe_t mon_w;
  always @(negedge clk) begin
    if (!rst) begin
      if (mem_store || mem_load) begin
        if (exp_mem.size() == 0) begin
          checks++; errors++;
          $display("FAIL mem_access: got store=%0b load=%0b, expected no access", mem_store, mem_load);
        end else begin
          mon_e = exp_mem.pop_front();
          chk("mem_store", 32'(mem_store), 32'(mon_e.st));
          chk("mem_load", 32'(mem_load), 32'(mon_e.ld));
          chk("mem_address", mem_address, mon_e.addr);
          if (mon_e.st) begin
            chk("mem_mask", 32'(mem_mask), 32'(mon_e.mask));
            chk("mem_wdata_lanes", mem_wdata & lanes(mon_e.mask), mon_e.wdata);
          end
        end
      end else if (exp_mem.size() != 0) begin
        mon_e = exp_mem.pop_front();
        checks++; errors++;
        $display("FAIL mem_missing: got no access, expected store=%0b load=%0b addr=%h", mon_e.st, mon_e.ld, mon_e.addr);
      end
      if (!mem_store) chk("mem_mask_idle", 32'(mem_mask), 32'h0);

      if (wb_valid) begin
        if (exp_wb.size() == 0) begin
          checks++; errors++;
          $display("FAIL wb_unexpected: got wb_valid=1 rd=%0d, expected wb_valid=0", wb_rd);
        end else begin
          mon_w = exp_wb.pop_front();
          chk("wb_rd", 32'(wb_rd), 32'(mon_w.rd));
          chk("wb_reg_write", 32'(wb_reg_write), 32'(mon_w.rw));
          chk("wb_fault", 32'(wb_fault), 32'(mon_w.fault));
          if (mon_w.fault) begin
            chk("wb_cause", 32'(wb_cause), 32'(mon_w.cause));
            chk("wb_bad_addr", wb_bad_addr, mon_w.bad);
          end else begin
            chk("wb_data", wb_data, mon_w.data);
          end
        end
      end
    end
  end

  task automatic check_wb_zero(input string tag);
    chk({tag, "_valid"}, 32'(wb_valid), 32'h0);
    chk({tag, "_rd"}, 32'(wb_rd), 32'h0);
    chk({tag, "_reg_write"}, 32'(wb_reg_write), 32'h0);
    chk({tag, "_data"}, wb_data, 32'h0);
    chk({tag, "_fault"}, 32'(wb_fault), 32'h0);
    chk({tag, "_cause"}, 32'(wb_cause), 32'h0);
    chk({tag, "_bad_addr"}, wb_bad_addr, 32'h0);
  endtask

  task automatic random_burst(input int n);
    req_t cur;
    logic hold;
    hold = 1'b0;
    cur  = rnd();
    for (int i = 0; i < n; i++) begin
      if (!hold) cur = rnd();
      cur.stall = ($urandom % 5) == 0;
      cur.flush = ($urandom % 12) == 0;
      drive(cur);
      tick();
      hold = cur.stall && !cur.flush;
    end
  endtask

  initial begin
    logic [31:0] w;
    rst = 1'b1;
    in_valid = 0; in_load = 0; in_store = 0; in_funct3 = '0; in_addr = '0;
    in_wdata = '0; in_alu_result = '0; in_rd = '0; in_reg_write = 0;
    stall = 0; flush = 0;
    m_valid = 1'b0;
    m_wb = '0;
    for (int i = 0; i < 256; i++) begin
      w = (i == 1) ? 32'h8001_1234 : $urandom;
      dmem[i] = w;
      for (int j = 0; j < 4; j++) ref_b[4*i + j] = w[8*j +: 8];
    end
    #3;
    check_wb_zero("reset");
    @(posedge clk);
    #1;
    rst = 1'b0;

    // halfword/word loads from word 1 (0x8001_1234)
    drive(mk(1, 1, 0, 3'd5, 32'h6, 0, 0, 5'd1, 1, 0, 0)); tick();
    chk("tp_lhu", wb_data, 32'h0000_8001);
    drive(mk(1, 1, 0, 3'd1, 32'h6, 0, 0, 5'd2, 1, 0, 0)); tick();
    chk("tp_lh", wb_data, 32'hFFFF_8001);
    drive(mk(1, 1, 0, 3'd2, 32'h4, 0, 0, 5'd3, 1, 0, 0)); tick();
    chk("tp_lw", wb_data, 32'h8001_1234);

    // SB then sign/zero-extending byte loads
    drive(mk(1, 0, 1, 3'd0, 32'h5, 32'h0000_00AB, 0, 5'd0, 0, 0, 0));
    #1;
    chk("tp_sb_addr", mem_address, 32'h1);
    chk("tp_sb_mask", 32'(mem_mask), 32'h2);
    chk("tp_sb_wdata", mem_wdata, 32'hABAB_ABAB);
    tick();
    drive(mk(1, 1, 0, 3'd0, 32'h5, 0, 0, 5'd4, 1, 0, 0)); tick();
    chk("tp_lb", wb_data, 32'hFFFF_FFAB);
    drive(mk(1, 1, 0, 3'd4, 32'h5, 0, 0, 5'd5, 1, 0, 0)); tick();
    chk("tp_lbu", wb_data, 32'h0000_00AB);

    // misaligned SH and illegal SB
    drive(mk(1, 0, 1, 3'd1, 32'h3, 32'h1234, 0, 5'd6, 1, 0, 0));
    #1;
    chk("tp_sh_mis_store", 32'(mem_store), 32'h0);
    chk("tp_sh_mis_mask", 32'(mem_mask), 32'h0);
    tick();
    chk("tp_sh_mis_fault", 32'(wb_fault), 32'h1);
    chk("tp_sh_mis_cause", 32'(wb_cause), 32'h0);
    chk("tp_sh_mis_bad", wb_bad_addr, 32'h3);
    chk("tp_sh_mis_rw", 32'(wb_reg_write), 32'h0);
    drive(mk(1, 0, 1, 3'd3, 32'h10, 32'h55, 0, 5'd7, 1, 0, 0)); tick();
    chk("tp_ill_cause", 32'(wb_cause), 32'h1);

    // SW held by stall for three cycles commits once
    for (int i = 0; i < 3; i++) begin
      drive(mk(1, 0, 1, 3'd2, 32'h8, 32'hCAFE_F00D, 0, 5'd0, 0, 1, 0));
      #1;
      chk("tp_stall_store", 32'(mem_store), 32'h0);
      tick();
      chk("tp_stall_frozen", 32'(wb_cause), 32'h1);
    end
    drive(mk(1, 0, 1, 3'd2, 32'h8, 32'hCAFE_F00D, 0, 5'd0, 0, 0, 0));
    #1;
    chk("tp_unstall_store", 32'(mem_store), 32'h1);
    chk("tp_unstall_mask", 32'(mem_mask), 32'hF);
    tick();
    drive(mk(1, 1, 0, 3'd2, 32'h8, 0, 0, 5'd8, 1, 0, 0)); tick();
    chk("tp_sw_readback", wb_data, 32'hCAFE_F00D);

    // flush together with stall on a live load
    drive(mk(1, 1, 0, 3'd2, 32'h8, 0, 0, 5'd9, 1, 1, 1));
    #1;
    chk("tp_flush_load", 32'(mem_load), 32'h0);
    tick();
    chk("tp_flush_valid", 32'(wb_valid), 32'h0);
    chk("tp_flush_rw", 32'(wb_reg_write), 32'h0);

    random_burst(400);

    // asynchronous reset between edges while a stalled instruction is held
    drive(mk(1, 1, 0, 3'd2, 32'h4, 0, 0, 5'd10, 1, 0, 0)); tick();
    drive(mk(1, 1, 0, 3'd2, 32'h4, 0, 0, 5'd10, 1, 1, 0)); tick();
    chk("tp_prereset_valid", 32'(wb_valid), 32'h1);
    #2;
    in_valid = 1'b0;
    stall = 1'b0;
    rst = 1'b1;
    exp_wb.delete();
    exp_mem.delete();
    m_valid = 1'b0;
    #1;
    check_wb_zero("async_reset");
    @(posedge clk);
    #1;
    rst = 1'b0;

    random_burst(150);

    for (int i = 0; i < 3; i++) begin
      drive(mk(0, 0, 0, 3'd0, 0, 0, 0, 5'd0, 0, 0, 0));
      tick();
    end
    #5;
    chk("wb_queue_drained", 32'(exp_wb.size()), 32'h0);
    chk("mem_queue_drained", 32'(exp_mem.size()), 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
